// File: rtl/rv_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, write modes,
// mstatus/mie field layout, and CSR decode/apply helpers.
package rv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_W    = 2'b01,
        CSR_S    = 2'b10,
        CSR_C    = 2'b11
    } csr_mode_e;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MEIE_BIT     = 11;

    localparam logic [31:0] MSTATUS_FIXED   = 32'h0000_1800;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [31:0] MCAUSE_ILLEGAL_INSTR = 32'h0000_0002;
    localparam logic [31:0] MCAUSE_ECALL_M       = 32'h0000_000B;
    localparam logic [31:0] MCAUSE_M_EXT_INT     = 32'h8000_000B;

    typedef struct packed {
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mip;
        logic [63:0] mcycle;
        logic [63:0] minstret;
    } csr_view_t;

    function automatic logic [31:0] csr_apply(input csr_mode_e mode, input logic [31:0] old_val,
                                              input logic [31:0] wval);
        logic [31:0] res;
        case (mode)
            CSR_W:   res = wval;
            CSR_S:   res = old_val | wval;
            CSR_C:   res = old_val & ~wval;
            default: res = old_val;
        endcase
        return res;
    endfunction

    function automatic logic csr_implemented(input logic [11:0] addr);
        logic hit;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_MHARTID: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic csr_read_only(input logic [11:0] addr);
        logic ro;
        case (addr)
            CSR_MISA, CSR_MIP, CSR_MHARTID: ro = 1'b1;
            default:                        ro = 1'b0;
        endcase
        return ro;
    endfunction

    function automatic logic [31:0] csr_mux(input logic [11:0] addr, input csr_view_t v,
                                            input logic [31:0] misa, input logic [31:0] hartid);
        logic [31:0] r;
        case (addr)
            CSR_MSTATUS:   r = v.mstatus;
            CSR_MISA:      r = misa;
            CSR_MIE:       r = v.mie;
            CSR_MTVEC:     r = v.mtvec;
            CSR_MSCRATCH:  r = v.mscratch;
            CSR_MEPC:      r = v.mepc;
            CSR_MCAUSE:    r = v.mcause;
            CSR_MTVAL:     r = v.mtval;
            CSR_MIP:       r = v.mip;
            CSR_MCYCLE:    r = v.mcycle[31:0];
            CSR_MCYCLEH:   r = v.mcycle[63:32];
            CSR_MINSTRET:  r = v.minstret[31:0];
            CSR_MINSTRETH: r = v.minstret[63:32];
            CSR_MHARTID:   r = hartid;
            default:       r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_csr_if.sv
// Connection bundle between the interrupt/exception unit (master) and the CSR file (slave).
interface rv_csr_if;
    logic [11:0] raddr;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic [31:0] rdata;
    logic        illegal_addr;
    logic        expt_int;
    logic [31:0] mepc_bypass_in;
    logic [31:0] mcause_bypass_in;
    logic [31:0] mtval_bypass_in;
    logic        mret;
    logic        ext_int;
    logic        instr_retire;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        int_pending;

    modport master (
        output raddr, waddr, wdata, csr_w, csr_wsc_mode, expt_int, mepc_bypass_in,
               mcause_bypass_in, mtval_bypass_in, mret, ext_int, instr_retire,
        input  rdata, illegal_addr, mtvec_out, mepc_out, int_pending
    );

    modport slave (
        input  raddr, waddr, wdata, csr_w, csr_wsc_mode, expt_int, mepc_bypass_in,
               mcause_bypass_in, mtval_bypass_in, mret, ext_int, instr_retire,
        output rdata, illegal_addr, mtvec_out, mepc_out, int_pending
    );
endinterface

// File: rtl/rv_csr_counter64.sv
// 64-bit free-running counter whose halves can be overwritten independently;
// a write cycle holds the count instead of incrementing.
module rv_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wval_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Next count: a half-write replaces that half only, with no carry between halves
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wval_i;
        end else if (wr_hi_i) begin
            cnt_d[63:32] = wval_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rv_csr_file.sv
// Machine-mode CSR file: trap state, external-interrupt pending logic, mcycle/minstret,
// and the trap-vector / return-address outputs for PC selection.
module rv_csr_file
    import rv_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input logic     clk,
    input logic     rst,
    rv_csr_if.slave csr
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic [63:0] mcycle_s;
    logic [63:0] minstret_s;
    csr_view_t   view_s;
    csr_mode_e   mode_s;
    logic        wr_req_s;
    logic        wr_en_s;
    logic [31:0] old_s;
    logic [31:0] wval_s;

    assign mode_s   = csr_mode_e'(csr.csr_wsc_mode);
    assign wr_req_s = csr.csr_w && (mode_s != CSR_NONE);
    assign wr_en_s  = wr_req_s && csr_implemented(csr.waddr) && !csr_read_only(csr.waddr);

    // Architectural view of every CSR as software sees it
    always_comb begin
        view_s                           = '0;
        view_s.mstatus                   = MSTATUS_FIXED;
        view_s.mstatus[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        view_s.mstatus[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        view_s.mie[MIE_MEIE_BIT]         = mie_meie_q;
        view_s.mtvec                     = mtvec_q;
        view_s.mscratch                  = mscratch_q;
        view_s.mepc                      = mepc_q;
        view_s.mcause                    = mcause_q;
        view_s.mtval                     = mtval_q;
        view_s.mip[MIE_MEIE_BIT]         = csr.ext_int;
        view_s.mcycle                    = mcycle_s;
        view_s.minstret                  = minstret_s;
    end

    assign old_s  = csr_mux(csr.waddr, view_s, MISA_VAL, HART_ID);
    assign wval_s = csr_apply(mode_s, old_s, csr.wdata);

    // Next state: CSR write first, then mret and trap override the fields they own
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (wr_en_s) begin
            case (csr.waddr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval_s[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wval_s[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_meie_d = wval_s[MIE_MEIE_BIT];
                CSR_MTVEC:    mtvec_d    = wval_s & ADDR_ALIGN_MASK;
                CSR_MSCRATCH: mscratch_d = wval_s;
                CSR_MEPC:     mepc_d     = wval_s & ADDR_ALIGN_MASK;
                CSR_MCAUSE:   mcause_d   = wval_s;
                CSR_MTVAL:    mtval_d    = wval_s;
                default:      mtvec_d    = mtvec_q;
            endcase
        end else begin
            mtvec_d = mtvec_q;
        end
        if (csr.expt_int) begin
            mepc_d         = csr.mepc_bypass_in & ADDR_ALIGN_MASK;
            mcause_d       = csr.mcause_bypass_in;
            mtval_d        = csr.mtval_bypass_in;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (csr.mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else begin
            mepc_d = mepc_d;
        end
    end

    // Trap-state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & ADDR_ALIGN_MASK;
            mscratch_q     <= 32'h0000_0000;
            mepc_q         <= 32'h0000_0000;
            mcause_q       <= 32'h0000_0000;
            mtval_q        <= 32'h0000_0000;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // Counter writes are not subject to trap/mret priority
    rv_csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en_s && (csr.waddr == CSR_MCYCLE)),
        .wr_hi_i (wr_en_s && (csr.waddr == CSR_MCYCLEH)),
        .wval_i  (wval_s),
        .cnt_o   (mcycle_s)
    );

    rv_csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (csr.instr_retire && !csr.expt_int),
        .wr_lo_i (wr_en_s && (csr.waddr == CSR_MINSTRET)),
        .wr_hi_i (wr_en_s && (csr.waddr == CSR_MINSTRETH)),
        .wval_i  (wval_s),
        .cnt_o   (minstret_s)
    );

    assign csr.rdata        = csr_mux(csr.raddr, view_s, MISA_VAL, HART_ID);
    assign csr.illegal_addr = !csr_implemented(csr.raddr) ||
                              (wr_req_s && (!csr_implemented(csr.waddr) || csr_read_only(csr.waddr)));
    assign csr.mtvec_out    = mtvec_q;
    assign csr.mepc_out     = mepc_q;
    assign csr.int_pending  = mstatus_mie_q && mie_meie_q && csr.ext_int;

endmodule
